writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-back stage directly upstream of the 32x64 register file. It owns the register file's single write port (BusW/RW/RegWr).
- Merges two result sources:
  - the single-cycle primary path (ALU/memory), which has priority and never stalls;
  - a multi-cycle slow unit (multiply/divide), which uses a valid/ready handshake and is buffered in a small FIFO.
- Reports which registers have queued slow writes, so hazard logic can use the information.

Parameters:
- DEPTH, 2, slow-result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, consecutive cycles of a non-empty FIFO with no drain before StallReq asserts

Ports:
- Clk  input  1  clock; all state updates on posedge
- Rst_n  input  1  synchronous active-low reset
- PriValid  input  1  primary result valid this cycle
- PriRW  input  5  primary destination register
- PriData  input  64  primary result
- SlowValid  input  1  slow result offered
- SlowReady  output  1  FIFO can accept (combinational, = !full)
- SlowRW  input  5  slow destination register
- SlowData  input  64  slow result
- StallReq  output  1  request upstream to hold PriValid low
- BusW  output  64  register-file write data (registered)
- RW  output  5  register-file write address (registered)
- RegWr  output  1  register-file write enable (registered)
- Pending  output  32  bit n set = FIFO holds a live entry targeting Xn

Behaviour:
- Reset (Rst_n=0 at posedge):
  - RegWr=0, RW=31, BusW=0;
  - FIFO empty, all entries dead, starve counter=0;
  - Pending=0, StallReq=0, SlowReady=1.
- Latency: a selected write appears on BusW/RW/RegWr 1 cycle after selection.
  - Outputs are stable through the following negedge, when the register file captures.
- Selection each posedge, in priority order:
  - (1) PriValid=1 -> emit the primary write.
  - (2) otherwise, if the FIFO is non-empty -> pop the head. Emit it if live; a dead head is popped with RegWr=0.
  - (3) otherwise -> RegWr=0; RW/BusW hold their previous values.
- Register 31 is never written:
  - any selected write with RW=31 produces RegWr=0;
  - a slow result with SlowRW=31 is accepted and enqueued dead.
- Enqueue: occurs when SlowValid && SlowReady at posedge. The entry is live unless squashed as below.
  - When full, SlowReady=0. There is no same-cycle enqueue-on-dequeue when full.
- Squash, for ordering (a primary write is always younger than any queued or simultaneously offered slow result):
  - when PriValid=1 with PriRW=r (r!=31), every live FIFO entry with RW=r becomes dead;
  - a slow result enqueued in the same cycle with SlowRW=r enqueues dead.
- Pending[n] = OR over live entries with RW=n. It updates on the same posedge as enqueue, pop and squash. Pending[31] is always 0.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and PriValid=1.
  - It clears on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - StallReq (registered) = counter==STARVE_LIMIT.
  - While StallReq=1, upstream must drive PriValid=0, so the next cycle pops.
  - If PriValid=1 arrives while StallReq=1, it is still honoured (primary priority holds) and StallReq stays high.
- Pointer arithmetic is modulo DEPTH. The count is log2(DEPTH)+1 bits. Full = count==DEPTH.
- Reset mid-operation: queued entries are discarded, not written back.

Decomposition:
- Shared package wb_pkg:
  - REG_W=64, ADDR_W=5, ZERO_REG=5'd31;
  - struct wb_entry_t {live, rw[4:0], data[63:0]}.
- One natural sub-module, wb_fifo: DEPTH-entry circular buffer.
  - Per-entry live bit, with a squash-by-address input.
  - Exposes head, count and the per-entry live/rw vector for Pending generation.
- Arbitration, squash and starve logic stay in the top level.

Test Plan:
- Primary-only: PriValid=1, PriRW=3, PriData=0x11 -> next cycle RegWr=1, RW=3, BusW=0x11. At the following negedge, X3 reads 0x11.
- Slow drain when idle:
  - stimulus: SlowValid=1, SlowRW=5, SlowData=0xABCD with primary idle;
  - response: Pending[5]=1 for 1 cycle, then RegWr=1, RW=5, BusW=0xABCD, Pending=0.
- Full backpressure:
  - stimulus: primary busy on X1 every cycle, with 3 slow offers to X6, X7, X8;
  - response: SlowReady=0 after 2 accepts, and the third offer is held. StallReq=1 after 4 busy cycles. Dropping PriValid pops X6, then X7.
- Squash:
  - stimulus: enqueue a slow write to X9=0x1, then a primary write X9=0x2;
  - response: Pending[9] clears; the later pop gives RegWr=0; X9 ends at 0x2.
- Zero register: PriRW=31 or SlowRW=31 -> RegWr never 1 with RW=31; Pending[31]=0.
- Reset mid-queue: 2 entries queued, Rst_n=0 for 1 cycle -> RegWr=0, RW=31, BusW=0, Pending=0, SlowReady=1, and no queued write is ever emitted.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, zero-register constant and FIFO entry type for the write-back stage
package wb_pkg;

    localparam int REG_W = 64;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] rw;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

    // X31 is hard-wired, so a write aimed at it must never reach the register file
    function automatic logic writable(input logic [ADDR_W-1:0] r);
        return r != ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of slow-unit results with per-entry live bits and squash-by-address
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    squash,
    input  logic [ADDR_W-1:0]       squash_rw,
    output wb_entry_t               head,
    output logic [PW:0]             count,
    output logic [DEPTH-1:0]        live_vec,
    output logic [DEPTH*ADDR_W-1:0] rw_vec
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != (PW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Squash kills matching entries; popped slots are also killed so live bits only mark occupied slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (squash && mem[i].rw == squash_rw) mem[i].live <= 1'b0;
            if (do_pop) mem[rd_ptr].live <= 1'b0;
            if (do_push) mem[wr_ptr] <= push_entry;
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Flatten per-entry live/address for the owner's Pending map
    always_comb begin
        live_vec = '0;
        rw_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i]               = mem[i].live;
            rw_vec[i*ADDR_W +: ADDR_W] = mem[i].rw;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the register-file write port, merging the primary path with queued slow results
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PriValid,
    input  logic [4:0]  PriRW,
    input  logic [63:0] PriData,
    input  logic        SlowValid,
    output logic        SlowReady,
    input  logic [4:0]  SlowRW,
    input  logic [63:0] SlowData,
    output logic        StallReq,
    output logic [63:0] BusW,
    output logic [4:0]  RW,
    output logic        RegWr,
    output logic [31:0] Pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t               head;
    wb_entry_t               push_entry;
    logic [PW:0]             count;
    logic [DEPTH-1:0]        live_vec;
    logic [DEPTH*ADDR_W-1:0] rw_vec;
    logic [CW-1:0]           starve;
    logic                    empty;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    squash;

    assign empty     = count == '0;
    assign full      = count == (PW+1)'(DEPTH);
    assign SlowReady = !full;
    assign push      = SlowValid && !full;
    assign pop       = !PriValid && !empty;
    assign squash    = PriValid && writable(PriRW);
    assign StallReq  = starve == CW'(STARVE_LIMIT);

    // A slow result racing a same-address primary write is older, so it arrives already dead
    assign push_entry = '{
        live: writable(SlowRW) && !(squash && PriRW == SlowRW),
        rw:   SlowRW,
        data: SlowData
    };

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .squash     (squash),
        .squash_rw  (PriRW),
        .head       (head),
        .count      (count),
        .live_vec   (live_vec),
        .rw_vec     (rw_vec)
    );

    // Primary wins; otherwise drain the FIFO head; idle cycles keep RW/BusW and drop the enable
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            RegWr <= 1'b0;
            RW    <= ZERO_REG;
            BusW  <= '0;
        end else if (PriValid) begin
            RegWr <= writable(PriRW);
            RW    <= PriRW;
            BusW  <= PriData;
        end else if (pop) begin
            RegWr <= head.live && writable(head.rw);
            RW    <= head.rw;
            BusW  <= head.data;
        end else begin
            RegWr <= 1'b0;
        end
    end

    // Count consecutive blocked cycles with work queued; saturate so StallReq holds until a pop
    always_ff @(posedge Clk) begin
        if (!Rst_n || pop || empty)
            starve <= '0;
        else if (PriValid && starve != CW'(STARVE_LIMIT))
            starve <= starve + CW'(1);
    end

    // Pending reflects live queued writes; X31 can never be pending
    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_vec[i]) Pending[rw_vec[i*ADDR_W +: ADDR_W]] = 1'b1;
        Pending[31] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus checked against a queue-level reference model
module tb_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic        live;
        logic [4:0]  rw;
        logic [63:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pv;
    logic [4:0]  prw;
    logic [63:0] pd;
    logic        sv;
    logic [4:0]  srw;
    logic [63:0] sd;
    logic        ready;
    logic        stall;
    logic [63:0] busw;
    logic [4:0]  rw;
    logic        regwr;
    logic [31:0] pending;

    logic [63:0] rf [32] = '{default: '0};

    ent_t        mq[$];
    logic        m_regwr;
    logic [4:0]  m_rw;
    logic [63:0] m_busw;
    int          m_cnt;
    bit          known = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          idx;
    bit          acc;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .PriValid  (pv),
        .PriRW     (prw),
        .PriData   (pd),
        .SlowValid (sv),
        .SlowReady (ready),
        .SlowRW    (srw),
        .SlowData  (sd),
        .StallReq  (stall),
        .BusW      (busw),
        .RW        (rw),
        .RegWr     (regwr),
        .Pending   (pending)
    );

    always #5 clk = ~clk;

    // Register file captures on the negedge following each write
    always @(negedge clk) if (regwr === 1'b1) rf[rw] <= busw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a FIFO queue of {live,rw,data}, primary-first selection, saturating starve count
    task automatic model_edge();
        bit   was_empty;
        bit   accept;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_regwr = 1'b0;
            m_rw    = 5'd31;
            m_busw  = '0;
            m_cnt   = 0;
            known   = 1'b1;
            return;
        end
        was_empty = mq.size() == 0;
        accept    = sv && mq.size() < DEPTH;
        if ((!pv && !was_empty) || was_empty) m_cnt = 0;
        else if (m_cnt < LIMIT) m_cnt++;
        if (pv) begin
            m_regwr = prw != 5'd31;
            m_rw    = prw;
            m_busw  = pd;
            if (prw != 5'd31) foreach (mq[i]) if (mq[i].rw == prw) mq[i].live = 1'b0;
        end else if (!was_empty) begin
            e       = mq.pop_front();
            m_regwr = e.live;
            m_rw    = e.rw;
            m_busw  = e.data;
        end else begin
            m_regwr = 1'b0;
        end
        if (accept) begin
            e.live = srw != 5'd31 && !(pv && prw == srw);
            e.rw   = srw;
            e.data = sd;
            mq.push_back(e);
        end
    endtask

    task automatic step();
        logic [31:0] mp;
        if (known) chk("ready_pre", ready, mq.size() < DEPTH);
        @(posedge clk);
        model_edge();
        #1;
        mp = '0;
        foreach (mq[i]) if (mq[i].live) mp[mq[i].rw] = 1'b1;
        chk("regwr", regwr, m_regwr);
        chk("rw", rw, m_rw);
        chk("busw", busw, m_busw);
        chk("pending", pending, mp);
        chk("stall", stall, m_cnt == LIMIT);
        chk("ready", ready, mq.size() < DEPTH);
        chk("no_x31_write", regwr === 1'b1 && rw === 5'd31, 1'b0);
    endtask

    task automatic idle(input int n);
        pv = 1'b0;
        sv = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom % 5;
        return r == 4 ? 5'd31 : 5'(r + 4);
    endfunction

    initial begin
        rst_n = 1'b0; pv = 1'b0; prw = '0; pd = '0; sv = 1'b0; srw = '0; sd = '0;
        step();
        step();
        chk("reset_rw", rw, 5'd31);
        chk("reset_ready", ready, 1'b1);
        rst_n = 1'b1;

        // primary-only write reaches X3
        pv = 1'b1; prw = 5'd3; pd = 64'h11;
        step();
        chk("pri_regwr", regwr, 1'b1);
        idle(1);
        chk("pri_rf_x3", rf[3], 64'h11);

        // slow result drains when primary is idle
        sv = 1'b1; srw = 5'd5; sd = 64'hABCD;
        step();
        chk("slow_pending5", pending[5], 1'b1);
        idle(1);
        chk("slow_busw", busw, 64'hABCD);
        chk("slow_pending_clear", pending, 32'h0);
        idle(1);

        // backpressure: primary hogs the port while three slow offers arrive
        pv = 1'b1; prw = 5'd1; pd = 64'h1; idx = 0;
        for (int c = 0; c < 6; c++) begin
            sv = idx < 3; srw = 5'(6 + idx); sd = 64'h60 + 64'(idx);
            acc = sv && ready;
            step();
            if (acc) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_full", ready, 1'b0);
        chk("bp_stall", stall, 1'b1);
        pv = 1'b0;
        for (int c = 0; c < 4 && idx < 3; c++) begin
            acc = ready;
            step();
            if (acc) idx++;
        end
        idle(4);
        chk("bp_x6", rf[6], 64'h60);
        chk("bp_x7", rf[7], 64'h61);
        chk("bp_x8", rf[8], 64'h62);

        // queued slow write squashed by a younger primary write
        sv = 1'b1; srw = 5'd9; sd = 64'h1; pv = 1'b0;
        step();
        chk("sq_pending9", pending[9], 1'b1);
        sv = 1'b0; pv = 1'b1; prw = 5'd9; pd = 64'h2;
        step();
        chk("sq_pending9_clear", pending[9], 1'b0);
        idle(1);
        chk("sq_dead_pop", regwr, 1'b0);
        idle(1);
        chk("sq_x9", rf[9], 64'h2);

        // simultaneous offer and primary write to the same register
        pv = 1'b1; prw = 5'd10; pd = 64'h3; sv = 1'b1; srw = 5'd10; sd = 64'h4;
        step();
        idle(3);
        chk("sq_same_x10", rf[10], 64'h3);

        // X31 is never written from either path
        pv = 1'b1; prw = 5'd31; pd = 64'hDEAD; sv = 1'b1; srw = 5'd31; sd = 64'hBEEF;
        step();
        chk("zero_pri", regwr, 1'b0);
        idle(3);
        chk("zero_rf31", rf[31], 64'h0);

        // reset with two entries queued discards them
        pv = 1'b1; prw = 5'd2; pd = 64'h5; sv = 1'b1; srw = 5'd12; sd = 64'h12;
        step();
        srw = 5'd13; sd = 64'h13;
        step();
        pv = 1'b0; sv = 1'b0; rst_n = 1'b0;
        step();
        chk("rst_busw", busw, 64'h0);
        chk("rst_pending", pending, 32'h0);
        rst_n = 1'b1;
        idle(3);
        chk("rst_x12", rf[12], 64'h0);
        chk("rst_x13", rf[13], 64'h0);

        // random traffic, mostly honouring StallReq, with rare resets
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom % 60) != 0;
            pv    = stall ? ($urandom % 6 == 0) : ($urandom % 3 != 0);
            prw   = pick();
            pd    = {$urandom, $urandom};
            sv    = $urandom % 2;
            srw   = pick();
            sd    = {$urandom, $urandom};
            step();
        end
        rst_n = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
